// File: rtl/scr1_pipe_mprf_wb.sv
// MPRF writeback initiator: merges ALU and long-latency results onto the single
// register-file write port and scoreboards long-op destinations for issue stalls.
module scr1_pipe_mprf_wb #(
  parameter int XLEN     = 32,
  parameter int AWIDTH   = 5,
  parameter int LQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_vd_i,
  input  logic [AWIDTH-1:0] iss_rs1_addr_i,
  input  logic [AWIDTH-1:0] iss_rs2_addr_i,
  input  logic [AWIDTH-1:0] iss_rd_addr_i,
  input  logic              iss_rd_long_i,
  output logic              iss_stall_o,
  input  logic              alu_wb_vd_i,
  input  logic [AWIDTH-1:0] alu_wb_addr_i,
  input  logic [XLEN-1:0]   alu_wb_data_i,
  input  logic              lng_wb_vd_i,
  input  logic [XLEN-1:0]   lng_wb_data_i,
  output logic              lng_wb_rdy_o,
  output logic              exu2mprf_w_req_o,
  output logic [AWIDTH-1:0] exu2mprf_rd_addr_o,
  output logic [XLEN-1:0]   exu2mprf_rd_data_o
);

  localparam int NREG  = 1 << AWIDTH;
  localparam int LQ_AW = (LQ_DEPTH > 2) ? $clog2(LQ_DEPTH) : 1;
  localparam logic [LQ_AW:0]   LQ_FULL_CNT = (LQ_AW + 1)'(LQ_DEPTH);
  localparam logic [LQ_AW:0]   CNT_ONE     = (LQ_AW + 1)'(1'b1);
  localparam logic [LQ_AW-1:0] PTR_ONE     = LQ_AW'(1'b1);

  logic [NREG-1:0]   pend_q, pend_d;
  logic [AWIDTH-1:0] lq_mem_q [LQ_DEPTH];
  logic [AWIDTH-1:0] lq_mem_d [LQ_DEPTH];
  logic [LQ_AW-1:0]  lq_rd_ptr_q, lq_rd_ptr_d;
  logic [LQ_AW-1:0]  lq_wr_ptr_q, lq_wr_ptr_d;
  logic [LQ_AW:0]    lq_cnt_q, lq_cnt_d;
  logic              sk_vd_q, sk_vd_d;
  logic [AWIDTH-1:0] sk_addr_q, sk_addr_d;
  logic [XLEN-1:0]   sk_data_q, sk_data_d;

  logic              lq_full_s, lq_empty_s;
  logic              iss_acc_s, lq_push_s, lq_pop_s;
  logic [AWIDTH-1:0] lng_addr_s;
  logic              sel_vd_s, lng_wr_vd_s, sk_load_s, sk_clr_s;
  logic [AWIDTH-1:0] sel_addr_s;
  logic [XLEN-1:0]   sel_data_s;

  // Issue hazard detection and long-result acceptance
  always_comb begin
    lq_full_s   = (lq_cnt_q == LQ_FULL_CNT);
    lq_empty_s  = (lq_cnt_q == '0);
    iss_stall_o = iss_vd_i & (pend_q[iss_rs1_addr_i] | pend_q[iss_rs2_addr_i]
                             | pend_q[iss_rd_addr_i] | (iss_rd_long_i & lq_full_s));
    iss_acc_s    = iss_vd_i & ~iss_stall_o;
    lq_push_s    = iss_acc_s & iss_rd_long_i;
    lng_wb_rdy_o = ~sk_vd_q;
    // A result arriving with nothing outstanding is dropped without popping
    lq_pop_s     = lng_wb_vd_i & ~sk_vd_q & ~lq_empty_s;
    lng_addr_s   = lq_mem_q[lq_rd_ptr_q];
  end

  // Write-port arbitration: ALU first, then skid, then pass-through long result
  always_comb begin
    sel_vd_s    = 1'b0;
    sel_addr_s  = '0;
    sel_data_s  = '0;
    lng_wr_vd_s = 1'b0;
    sk_load_s   = 1'b0;
    sk_clr_s    = 1'b0;
    if (alu_wb_vd_i) begin
      sel_vd_s   = 1'b1;
      sel_addr_s = alu_wb_addr_i;
      sel_data_s = alu_wb_data_i;
      sk_load_s  = lq_pop_s;
    end else if (sk_vd_q) begin
      sel_vd_s    = 1'b1;
      sel_addr_s  = sk_addr_q;
      sel_data_s  = sk_data_q;
      lng_wr_vd_s = 1'b1;
      sk_clr_s    = 1'b1;
    end else if (lq_pop_s) begin
      sel_vd_s    = 1'b1;
      sel_addr_s  = lng_addr_s;
      sel_data_s  = lng_wb_data_i;
      lng_wr_vd_s = 1'b1;
    end else begin
      sel_vd_s = 1'b0;
    end
    exu2mprf_w_req_o   = sel_vd_s & (sel_addr_s != '0);
    exu2mprf_rd_addr_o = sel_addr_s;
    exu2mprf_rd_data_o = sel_data_s;
  end

  // Next state for scoreboard, destination queue and skid buffer
  always_comb begin
    pend_d      = pend_q;
    lq_mem_d    = lq_mem_q;
    lq_rd_ptr_d = lq_rd_ptr_q;
    lq_wr_ptr_d = lq_wr_ptr_q;
    sk_vd_d     = sk_vd_q;
    sk_addr_d   = sk_addr_q;
    sk_data_d   = sk_data_q;

    if (lng_wr_vd_s) begin
      pend_d[sel_addr_s] = 1'b0;
    end else begin
      pend_d = pend_d;
    end
    if (lq_push_s) begin
      pend_d[iss_rd_addr_i] = (iss_rd_addr_i != '0);
      lq_mem_d[lq_wr_ptr_q] = iss_rd_addr_i;
      lq_wr_ptr_d           = lq_wr_ptr_q + PTR_ONE;
    end else begin
      lq_wr_ptr_d = lq_wr_ptr_q;
    end
    pend_d[0] = 1'b0;

    if (lq_pop_s) begin
      lq_rd_ptr_d = lq_rd_ptr_q + PTR_ONE;
    end else begin
      lq_rd_ptr_d = lq_rd_ptr_q;
    end

    case ({lq_push_s, lq_pop_s})
      2'b10:   lq_cnt_d = lq_cnt_q + CNT_ONE;
      2'b01:   lq_cnt_d = lq_cnt_q - CNT_ONE;
      default: lq_cnt_d = lq_cnt_q;
    endcase

    if (sk_load_s) begin
      sk_vd_d   = 1'b1;
      sk_addr_d = lng_addr_s;
      sk_data_d = lng_wb_data_i;
    end else if (sk_clr_s) begin
      sk_vd_d = 1'b0;
    end else begin
      sk_vd_d = sk_vd_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      lq_rd_ptr_q <= '0;
      lq_wr_ptr_q <= '0;
      lq_cnt_q    <= '0;
      sk_vd_q     <= 1'b0;
      sk_addr_q   <= '0;
      sk_data_q   <= '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_mem_q[i] <= '0;
      end
    end else begin
      pend_q      <= pend_d;
      lq_rd_ptr_q <= lq_rd_ptr_d;
      lq_wr_ptr_q <= lq_wr_ptr_d;
      lq_cnt_q    <= lq_cnt_d;
      sk_vd_q     <= sk_vd_d;
      sk_addr_q   <= sk_addr_d;
      sk_data_q   <= sk_data_d;
      lq_mem_q    <= lq_mem_d;
    end
  end

  scr1_pipe_mprf_wb_chk u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .lng_wb_vd_i  (lng_wb_vd_i),
    .lng_wb_rdy_i (lng_wb_rdy_o),
    .lq_empty_i   (lq_empty_s)
  );

endmodule

// Protocol checker: a long result must never arrive with no destination queued.
module scr1_pipe_mprf_wb_chk (
  input logic clk,
  input logic rst_n,
  input logic lng_wb_vd_i,
  input logic lng_wb_rdy_i,
  input logic lq_empty_i
);

  // Flag orphan long results
  a_lng_no_dest: assert property (@(posedge clk) disable iff (!rst_n)
    !(lng_wb_vd_i && lng_wb_rdy_i && lq_empty_i));

endmodule

// File: doc/scr1_pipe_mprf_wb.md
# scr1_pipe_mprf_wb

Writeback initiator and scoreboard for the MPRF write port. Merges single-cycle ALU results and out-of-band long-latency (LSU/MUL/DIV) results onto the MPRF write interface. Tracks destination registers of in-flight long operations and stalls issue on RAW/WAW hazards. Sits in the EXU between the functional units and the register file.

## Interface
Parameters:
- XLEN, 32, data width
- AWIDTH, 5, register address width
- LQ_DEPTH, 2, outstanding long-op destination queue depth (power of 2, ≥2)

Ports (clock and reset: rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- iss_vd_i  in  1  instruction presented for issue
- iss_rs1_addr_i / iss_rs2_addr_i  in  AWIDTH  source registers
- iss_rd_addr_i  in  AWIDTH  destination register
- iss_rd_long_i  in  1  result returns via long path
- iss_stall_o  out  1  issue blocked this cycle (combinational)
- alu_wb_vd_i  in  1  ALU result valid
- alu_wb_addr_i  in  AWIDTH  ALU destination
- alu_wb_data_i  in  XLEN  ALU result
- lng_wb_vd_i  in  1  long result valid (results return in issue order)
- lng_wb_data_i  in  XLEN  long result
- lng_wb_rdy_o  out  1  long result accepted when vd & rdy
- exu2mprf_w_req_o  out  1  MPRF write request
- exu2mprf_rd_addr_o  out  AWIDTH  MPRF write address
- exu2mprf_rd_data_o  out  XLEN  MPRF write data

## Operation
- State: pend[2^AWIDTH-1:1] scoreboard; LQ address FIFO (LQ_DEPTH entries, rd_ptr/wr_ptr/count); 1-entry long-result skid buffer (sk_vd, sk_addr, sk_data).
- Issue accept = iss_vd_i & ~iss_stall_o.
- iss_stall_o = iss_vd_i & (pend[rs1] | pend[rs2] | pend[rd] | (iss_rd_long_i & LQ full)); pend[0] always reads 0.
- On accept with iss_rd_long_i: push iss_rd_addr_i into LQ (x0 included, keeps ordering); set pend[rd] if rd≠0.
- Long acceptance: lng_wb_rdy_o = ~sk_vd. On vd & rdy: pop LQ head as destination.
- Write-port arbitration, priority ALU > skid > new long result:
  - alu_wb_vd_i: write ALU; a concurrently accepted long result goes to skid.
  - else sk_vd: write skid, clear sk_vd.
  - else accepted long result: write directly (pass-through).
- exu2mprf_w_req_o suppressed when selected address is 0; the long result is still consumed and popped.
- pend[addr] clears at the clock edge on which the long write is presented (same edge MPRF stores it).
- Simultaneous set/clear of same pend bit is impossible (WAW stall); set-on-accept and clear-on-write of different bits in one cycle both apply.
- LQ push and pop in same cycle: count unchanged; full-state push allowed only if pop same cycle — not exploited, stall uses registered full.
- lng_wb_vd_i with LQ empty: ignored, no write; simulation assertion fires.
- ALU results are not scoreboarded: EXU guarantees ALU writeback precedes dependent issue.

## Timing
- Reset: pend=0, LQ empty, sk_vd=0; outputs iss_stall_o=0, lng_wb_rdy_o=1, exu2mprf_w_req_o=0, rd_addr_o=0, rd_data_o=0 (while no valid input).
- ALU write and direct long write: 0-cycle, combinational to MPRF port.
- Skidded long write: presented cycle N+1 if no ALU write, else waits; lng_wb_rdy_o low while sk_vd.
- Stall on dependent register released in the cycle after the long write edge; MPRF read that cycle returns new data.
- Reset asserted mid-operation: all state cleared immediately; in-flight long results lost (units reset in same domain).

## Test plan
- Reset: rst_n=0 then release, all inputs 0 -> w_req_o=0, lng_wb_rdy_o=1, iss_stall_o=0.
- Load x5 issued (long), next issue reads rs1=x5 -> stall high; lng_wb_vd with 0xDEADBEEF -> w_req, addr 5, data 0xDEADBEEF; next cycle stall low.
- ALU write x3=0x11 and long result 0x22 (dest x7) same cycle -> cycle N writes x3=0x11, rdy drops, cycle N+1 writes x7=0x22, rdy returns high.
- Two long ops x1, x2 outstanding, third long issue -> stall (LQ full); results return in order -> writes x1 then x2, third issue accepted after first pop.
- Long op to x0 -> no pend bit, no stall on later x0 read; result consumed with w_req_o=0.
- Reset asserted with x9 pending and skid full -> pend, LQ, skid cleared; read of x9 after release does not stall.
